cadder_seq: RTL and testbench

- Upstream issue stage for the two-phase half-width add/subtract unit (cadder).
- Buffers add/sub requests in a small FIFO and presents one operation at a time. Holds operands and the op flag stable while it asserts the adder enable for a fixed number of cycles.
- Captures the adder result and hands it downstream over a valid/ready handshake.
- Keeps the adder's multi-cycle timing out of the request and response producers.

---
 rtl/cadder_pkg.sv | 21 ++
 rtl/cadder_seq_sync_fifo.sv | 53 +++++
 rtl/cadder_seq.sv | 118 +++++++++++
 tb/tb_cadder_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cadder_pkg.sv
// Shared types and default sizing for the cadder issue stage.
package cadder_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ADD_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Queue entry layout at the default width; the FIFO stores {add, b, a}.
  typedef struct packed {
    logic                      add;
    logic [DEF_DATA_WIDTH-1:0] b;
    logic [DEF_DATA_WIDTH-1:0] a;
  } request_t;

endpackage

// File: rtl/cadder_seq_sync_fifo.sv
// Synchronous FIFO with occupancy count; no push/pop bypass in either direction.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cadder_seq.sv
// Issue stage for the multi-cycle cadder: queues requests, holds operands while
// the adder is enabled for ADD_LATENCY cycles, then hands the result downstream.
module cadder_seq
  import cadder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_a,
  input  logic [DATA_WIDTH-1:0]         in_b,
  input  logic                          in_add,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  output logic                          add_en,
  output logic                          add_enable,
  input  logic [DATA_WIDTH-1:0]         add_result,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int REQ_W = 2*DATA_WIDTH + 1;
  localparam int CNT_W = $clog2(ADD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_LATENCY - 1);

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [DATA_WIDTH-1:0]  add_a_d, add_b_d, res_data_d;
  logic                   add_en_d, res_valid_d;
  logic [REQ_W-1:0]       fifo_rdata;
  logic                   fifo_full, fifo_empty, fifo_pop;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata ({in_add, in_b, in_a}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign in_ready   = !fifo_full;
  assign add_enable = (state == RUN);
  assign busy       = (state != IDLE) || !fifo_empty;

  // NOTE: every signal written here gets a default first, so no latches can be inferred.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    add_a_d     = add_a;
    add_b_d     = add_b;
    add_en_d    = add_en;
    res_data_d  = res_data;
    res_valid_d = res_valid;
    fifo_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop                     = 1'b1;
          {add_en_d, add_b_d, add_a_d} = fifo_rdata;
          cnt_d                        = '0;
          state_d                      = RUN;
        end
      end
      RUN: begin
        // The adder's result is only guaranteed on its final enable cycle.
        if (cnt == CNT_LAST) begin
          res_data_d  = add_result;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_en    <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      add_a     <= add_a_d;
      add_b     <= add_b_d;
      add_en    <= add_en_d;
      res_data  <= res_data_d;
      res_valid <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_cadder_seq.sv
// Scoreboard bench for cadder_seq: stimulus pushes expectations, a negedge monitor checks them.
module tb_cadder_seq;
  import cadder_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int DEPTH = DEF_FIFO_DEPTH;
  localparam int LAT   = DEF_ADD_LATENCY;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, rst;
  logic          in_valid, in_ready, in_add;
  logic [DW-1:0] in_a, in_b;
  logic [DW-1:0] add_a, add_b, add_result;
  logic          add_en, add_enable;
  logic          res_valid, res_ready, busy;
  logic [DW-1:0] res_data;
  logic [CW-1:0] count;

  int n_vec  = 0;
  int n_fail = 0;
  int en_seen = 0;
  bit rand_ready = 0;

  request_t      op_q[$];
  logic [DW-1:0] exp_q[$];
  request_t      cur;
  bit            hold_seen = 0;
  logic [DW-1:0] hold_data;

  cadder_seq #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .ADD_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_add     (in_add),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_en     (add_en),
    .add_enable (add_enable),
    .add_result (add_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_op(input request_t r);
    if (r.add) return DW'(r.a + r.b);
    return DW'(r.a - r.b);
  endfunction

  // Adder model: correct only once enable has been high for LAT cycles, garbage before.
  assign add_result = (add_enable && en_seen == LAT) ? ref_op({add_en, add_b, add_a})
                                                     : ~ref_op({add_en, add_b, add_a});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: records accepted requests, checks adder drive and emitted results.
  always @(negedge clk) begin
    request_t r;
    if (rst) begin
      op_q.delete();
      exp_q.delete();
      en_seen   = 0;
      hold_seen = 0;
    end else begin
      if (in_valid && in_ready) begin
        r = {in_add, in_b, in_a};
        op_q.push_back(r);
        exp_q.push_back(ref_op(r));
      end
      if (add_enable) begin
        if (en_seen == 0) begin
          check("op_pending", 32'(op_q.size() != 0), 32'd1);
          if (op_q.size() != 0) begin
            cur = op_q.pop_front();
            check("op_a", 32'(add_a), 32'(cur.a));
            check("op_b", 32'(add_b), 32'(cur.b));
            check("op_flag", 32'(add_en), 32'(cur.add));
          end
        end else begin
          check("op_stable", 32'({add_en, add_b, add_a}), 32'(cur));
        end
        en_seen++;
      end else if (en_seen != 0) begin
        check("enable_len", 32'(en_seen), 32'(LAT));
        en_seen = 0;
      end
      if (res_valid) begin
        if (hold_seen) check("res_stable", 32'(res_data), 32'(hold_data));
        if (res_ready) begin
          check("res_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
          hold_seen = 0;
        end else begin
          hold_seen = 1;
          hold_data = res_data;
        end
      end else begin
        hold_seen = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic add);
    bit accepted = 0;
    int guard = 0;
    in_a = a; in_b = b; in_add = add; in_valid = 1'b1;
    while (!accepted && guard < 200) begin
      accepted = in_ready;
      step();
      guard++;
    end
    in_valid = 1'b0;
    check("push_accept", 32'(accepted), 32'd1);
  endtask

  task automatic wait_result(output logic [DW-1:0] d);
    int n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    check("res_seen", 32'(res_valid), 32'd1);
    d = res_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || res_valid || exp_q.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_add_a"}, 32'(add_a), 32'd0);
    check({tag, "_add_b"}, 32'(add_b), 32'd0);
    check({tag, "_add_en"}, 32'(add_en), 32'd0);
    check({tag, "_add_enable"}, 32'(add_enable), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int n;
    bit rdy_before;
    bit saw_valid;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_add = 1'b0; res_ready = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;

    // Single add: latency from accepting edge to res_valid, then back to idle.
    res_ready = 1'b1;
    push_op(8'h3C, 8'h15, 1'b1);
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'(LAT + 1));
    check("add_3c_15", 32'(res_data), 32'h51);
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_count", 32'(count), 32'd0);

    // Subtraction and wraparound.
    push_op(8'h10, 8'h01, 1'b0);
    wait_result(d);
    check("sub_10_01", 32'(d), 32'h0F);
    step();
    push_op(8'hFF, 8'h02, 1'b1);
    wait_result(d);
    check("add_wrap", 32'(d), 32'h01);
    step();

    // Fill the queue behind a held result.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_op(DW'(8'h20 + i), DW'(i), 1'(i % 2));
    check("fill_count3", 32'(count), 32'd3);
    push_op(8'h55, 8'h11, 1'b0);
    check("fill_count4", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);

    // Push while full as the FSM pops: refused, count drops by one, then accepted.
    in_a = 8'h77; in_b = 8'h88; in_add = 1'b1; in_valid = 1'b1;
    res_ready = 1'b1;
    n = 0;
    rdy_before = 1'b1;
    while (count == CW'(DEPTH) && n < 50) begin
      rdy_before = in_ready;
      step();
      n++;
    end
    check("pop_full_count", 32'(count), 32'(DEPTH - 1));
    check("pop_full_refused", 32'(rdy_before), 32'd0);
    rdy_before = in_ready;
    step();
    in_valid = 1'b0;
    check("push_after_pop", 32'(rdy_before), 32'd1);
    wait_idle();

    // Reset while an op is running with two more queued.
    push_op(8'h01, 8'h02, 1'b1);
    push_op(8'h03, 8'h04, 1'b1);
    push_op(8'h05, 8'h06, 1'b0);
    check("pre_rst_enable", 32'(add_enable), 32'd1);
    check("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("midrst");
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      saw_valid |= res_valid;
    end
    check("no_res_after_rst", 32'(saw_valid), 32'd0);
    push_op(8'h40, 8'h02, 1'b1);
    wait_result(d);
    check("post_rst_op", 32'(d), 32'h42);
    wait_idle();

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 3)) step();
      push_op(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    res_ready  = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "timeout");
  end

endmodule
